// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the two requester handshakes (fetch F, loader L), the memory
//   macro bus and the arbiter status lines into one interface.
//
//   Modports:
//     slave  - the arbiter: consumes requests and mem_rdata, drives acks,
//              read data, the memory strobe/address/data and status.
//     master - the surroundings (requesters + memory macro): the mirror image.
//
//   Signals:
//     f_req/f_addr -> f_ack/f_rdata                 fetch read channel
//     l_req/l_we/l_addr/l_wdata/l_lock -> l_ack/l_rdata  loader channel
//     mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata  memory macro bus
//     busy, gnt_l                                   arbiter status
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_rdata;

    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_lock;
    logic          l_ack;
    logic [DW-1:0] l_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic          gnt_l;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
        output f_ack, f_rdata, l_ack, l_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_l
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
        input  f_ack, f_rdata, l_ack, l_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_l
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between the instruction-fetch path (F)
//   and the program loader/debug port (L). Every access walks the fixed
//   sequence IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE, so only one
//   transaction is ever in flight. Arbitration is round-robin on gnt_l;
//   l_lock removes F from arbitration while a program is being downloaded.
//   All outputs come straight from registers.
//
//   Ports:
//     clk   - system clock, rising edge
//     CLB   - synchronous active-high reset; abandons any in-flight access
//     bus   - mem_arbiter_if.slave (requester channels, memory bus, status)
//
//   Parameters:
//     AW, DW   - address / data width
//     MEM_LAT  - memory read latency after the mem_en cycle, 1..4
module mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         CLB,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Counter reaches 0 in the cycle mem_rdata is valid.
    localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

    state_t        state_q,     state_d;
    logic [1:0]    cnt_q,       cnt_d;
    logic          mem_en_q,    mem_en_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          f_ack_q,     f_ack_d;
    logic          l_ack_q,     l_ack_d;
    logic [DW-1:0] f_rdata_q,   f_rdata_d;
    logic [DW-1:0] l_rdata_q,   l_rdata_d;
    logic          busy_q,      busy_d;
    logic          gnt_l_q,     gnt_l_d;

    logic f_elig;
    logic l_elig;
    logic grant_l;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        f_ack_d     = 1'b0;
        l_ack_d     = 1'b0;
        f_rdata_d   = f_rdata_q;
        l_rdata_d   = l_rdata_q;
        busy_d      = busy_q;
        gnt_l_d     = gnt_l_q;

        f_elig  = bus.f_req & ~bus.l_lock;
        l_elig  = bus.l_req;
        // With both eligible, the side that did not own the last grant wins.
        grant_l = (f_elig & l_elig) ? ~gnt_l_q : l_elig;

        unique case (state_q)
            S_IDLE: begin
                if (f_elig | l_elig) begin
                    gnt_l_d  = grant_l;
                    busy_d   = 1'b1;
                    mem_en_d = 1'b1;
                    if (grant_l) begin
                        mem_addr_d  = bus.l_addr;
                        mem_we_d    = bus.l_we;
                        mem_wdata_d = bus.l_wdata;
                    end else begin
                        mem_addr_d  = bus.f_addr;
                        mem_we_d    = 1'b0;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = WAIT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (!mem_we_q) begin
                        if (gnt_l_q) l_rdata_d = bus.mem_rdata;
                        else         f_rdata_d = bus.mem_rdata;
                    end
                    f_ack_d = ~gnt_l_q;
                    l_ack_d = gnt_l_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (CLB) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_ack_q     <= 1'b0;
            l_ack_q     <= 1'b0;
            f_rdata_q   <= '0;
            l_rdata_q   <= '0;
            busy_q      <= 1'b0;
            gnt_l_q     <= 1'b1;   // lets F win the first contention
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_ack_q     <= f_ack_d;
            l_ack_q     <= l_ack_d;
            f_rdata_q   <= f_rdata_d;
            l_rdata_q   <= l_rdata_d;
            busy_q      <= busy_d;
            gnt_l_q     <= gnt_l_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.f_ack     = f_ack_q;
    assign bus.l_ack     = l_ack_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.l_rdata   = l_rdata_q;
    assign bus.busy      = busy_q;
    assign bus.gnt_l     = gnt_l_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port program/data memory between two requesters: the instruction-fetch path (F) and the program loader/debug port (L).
- Sequences every memory access through a fixed-latency issue/wait/complete FSM.
- Arbitrates round-robin, with an optional loader lock used during program download.
- Sits between the CPU controller/PC and the memory macro.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MEM_LAT, 1, memory read latency in cycles after the cycle mem_en is high; legal range 1..4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- CLB  input  1  reset, synchronous, active-high.
- f_req  input  1  fetch read request, held until f_ack.
- f_addr  input  AW  fetch address, stable while f_req is high.
- f_ack  output  1  one-cycle fetch completion pulse.
- f_rdata  output  DW  fetch read data; valid with f_ack, held until the next F completion.
- l_req  input  1  loader request, held until l_ack.
- l_we  input  1  loader write enable (1=write, 0=read), stable with l_req.
- l_addr  input  AW  loader address.
- l_wdata  input  DW  loader write data.
- l_lock  input  1  when high, loader keeps priority and F is never granted.
- l_ack  output  1  one-cycle loader completion pulse.
- l_rdata  output  DW  loader read data; valid with l_ack, held.
- mem_en  output  1  memory access strobe, exactly one cycle per transaction.
- mem_we  output  1  memory write enable, qualified by mem_en.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  output  1  high in any state other than IDLE.
- gnt_l  output  1  current or last owner (0=F, 1=L).

Behaviour:
- All outputs are registered.
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, f_ack=0, l_ack=0, f_rdata=0, l_rdata=0, busy=0, gnt_l=1, state=IDLE, wait counter=0.
- gnt_l resets to 1 so that F wins the first contention.
- IDLE:
  - Samples requests; F is eligible only when l_lock=0.
  - Both eligible: grant the one that is not gnt_l (round-robin).
  - Only one eligible: grant it.
  - None eligible: stay in IDLE.
  - On a grant, register addr/we/wdata and gnt_l, then go to ISSUE.
  - F accesses always have mem_we=0.
- ISSUE: mem_en=1 for exactly this cycle; load counter with MEM_LAT-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter is 0, mem_rdata is valid; capture it into the granted requester's rdata register and go to DONE.
  - With MEM_LAT=1, WAIT lasts exactly one cycle.
- DONE: pulse the granted ack for one cycle; go to IDLE.
- Writes use identical timing; l_rdata is not updated on a write.
- Latency: request sampled in IDLE at cycle t gives mem_en at t+1 and ack at t+2+MEM_LAT. Throughput is one transaction per MEM_LAT+3 cycles.
- Requester rule: a requester must deassert req in the cycle after ack. A req still high in the IDLE cycle after DONE is treated as a new transaction.
- Only one transaction is in flight at a time.
- Requests and l_lock changes arriving while busy are ignored until IDLE.
- Raising l_lock mid-transaction does not abort an F transaction already granted.
- CLB high in any state: next cycle all outputs at reset values and state IDLE. An in-flight access is abandoned, no ack is issued, and late mem_rdata is ignored.
- Inputs are never combinationally passed to outputs.

Test Plan:
- Single fetch, MEM_LAT=1: f_req=1, f_addr=0x12 at cycle 0, memory returns 0xA5 -> mem_en=1/mem_we=0/mem_addr=0x12 at cycle 1; f_ack=1, f_rdata=0xA5 at cycle 3; busy high cycles 1-3.
- Loader write: l_req=1, l_we=1, l_addr=0x40, l_wdata=0x3C -> mem_en=1, mem_we=1, mem_wdata=0x3C at cycle 1; l_ack at cycle 3; l_rdata unchanged.
- Contention after reset: f_req and l_req held high together -> F granted first, then L, then F (gnt_l sequence 0,1,0); one ack per transaction; never both acks in the same cycle.
- Lock: l_lock=1 with f_req and l_req both high for 4 loader transactions -> only l_ack pulses and f_ack stays 0; drop l_lock -> F is granted at the next IDLE.
- MEM_LAT=3 build: single loader read -> mem_en at cycle 1, l_ack at cycle 5, captured data equals the mem_rdata present at cycle 4.
- Reset mid-op: assert CLB in the WAIT cycle of a fetch -> the next cycle has busy=0, mem_en=0, no f_ack; a new f_req afterwards completes normally with round-robin state reset (F wins over L).
